hysteresis_edge_track: RTL and testbench

//  Final Canny stage; consumes the 3-level stream from the double-threshold stage (0 / 1..254 / 255).

---
 rtl/hysteresis_edge_track_if.sv | 11 +
 rtl/hysteresis_edge_track.sv | 112 +++++++++++
 tb/tb_hysteresis_edge_track.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hysteresis_edge_track_if.sv
// hysteresis_edge_track_if: pixel stream in/out plus flush/overrun status
interface hysteresis_edge_track_if;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       busy;
   logic       overrun;
   modport master (output data_in, data_in_valid, input data_out, data_out_valid, busy, overrun);
   modport slave  (input data_in, data_in_valid, output data_out, data_out_valid, busy, overrun);
endinterface

// File: rtl/hysteresis_edge_track.sv
// hysteresis_edge_track: single-pass promotion of intermediate pixels next to strong ones
module hysteresis_edge_track #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input logic                    clk,
   input logic                    rst,
   hysteresis_edge_track_if.slave bus
);
   localparam int AW = $clog2(IMG_WIDTH);
   localparam int FW = $clog2(IMG_WIDTH + 1);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [AW-1:0] COL_LAST   = AW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);
   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
   state_t               state_q, state_d;
   logic [AW-1:0]        col_q, col_d, ocol_q, ocol_d;
   logic [RW-1:0]        row_q, row_d, orow_q, orow_d;
   logic [FW-1:0]        fcnt_q, fcnt_d;
   logic [2:0][2:0][7:0] win_q, win_d;
   logic [7:0]           lb0_q [IMG_WIDTH];
   logic [7:0]           lb1_q [IMG_WIDTH];
   logic [7:0]           data_out_q, data_out_d, res;
   logic                 valid_q, overrun_q, overrun_d;
   logic                 acc, emit, flush, strong_nb, border;
   // window shift: newest column is {row r-2, row r-1, incoming}; flush feeds zeros
   always_comb begin
      flush = state_q == FLUSH;
      acc   = bus.data_in_valid && !flush;
      emit  = flush || (acc && state_q == RUN);
      win_d = win_q;
      if (acc || flush) begin
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2] = flush ? 8'd0 : lb1_q[col_q];
         win_d[1][2] = flush ? 8'd0 : lb0_q[col_q];
         win_d[2][2] = flush ? 8'd0 : bus.data_in;
      end
   end
   // classify the centre of the freshly shifted window; output position drives border suppression
   always_comb begin
      strong_nb = 1'b0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            if (!(i == 1 && j == 1) && win_d[i][j] == 8'd255) strong_nb = 1'b1;
      border = ocol_q == '0 || ocol_q == COL_LAST || orow_q == '0 || orow_q == ROW_LAST;
      res    = (border || win_d[1][1] == 8'd0) ? 8'd0 :
               (win_d[1][1] == 8'd255 || strong_nb) ? 8'd255 : 8'd0;
   end
   // counters, overrun and FILL/RUN/FLUSH sequencing
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      ocol_d     = ocol_q;
      orow_d     = orow_q;
      overrun_d  = overrun_q || (bus.data_in_valid && flush);
      data_out_d = emit ? res : data_out_q;
      fcnt_d     = flush ? (fcnt_q == FLUSH_LAST ? '0 : fcnt_q + 1'b1) : fcnt_q;
      if (acc) begin
         col_d = col_q == COL_LAST ? '0 : col_q + 1'b1;
         row_d = col_q != COL_LAST ? row_q : (row_q == ROW_LAST ? '0 : row_q + 1'b1);
      end
      if (emit) begin
         ocol_d = ocol_q == COL_LAST ? '0 : ocol_q + 1'b1;
         orow_d = ocol_q != COL_LAST ? orow_q : (orow_q == ROW_LAST ? '0 : orow_q + 1'b1);
      end
      if (state_q == FILL && acc && row_q == RW'(1) && col_q == '0) state_d = RUN;
      if (state_q == RUN && acc && row_q == ROW_LAST && col_q == COL_LAST) state_d = FLUSH;
      if (flush && fcnt_q == FLUSH_LAST) state_d = FILL;
   end
   // state, window taps and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FILL;
         col_q      <= '0;
         row_q      <= '0;
         ocol_q     <= '0;
         orow_q     <= '0;
         fcnt_q     <= '0;
         win_q      <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         ocol_q     <= ocol_d;
         orow_q     <= orow_d;
         fcnt_q     <= fcnt_d;
         win_q      <= win_d;
         data_out_q <= data_out_d;
         valid_q    <= emit;
         overrun_q  <= overrun_d;
      end
   end
   // line buffers age one row per accepted pixel at the current column
   always_ff @(posedge clk) begin
      if (acc) begin
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= bus.data_in;
      end
   end
   assign bus.data_out       = data_out_q;
   assign bus.data_out_valid = valid_q;
   assign bus.busy           = state_q == FLUSH;
   assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_hysteresis_edge_track.sv
// tb_hysteresis_edge_track: directed frames on an 8x6 image against hand-derived results
module tb_hysteresis_edge_track;
   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   int busy_cnt = 0;
   logic [7:0] img [N];
   logic [7:0] outq [$];
   logic [7:0] refq [$];
   longint otq [$];
   longint itq [$];
   hysteresis_edge_track_if bus ();
   hysteresis_edge_track #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // capture every output pixel and count flush cycles away from the active edge
   always @(negedge clk) begin
      if (bus.data_out_valid) begin
         outq.push_back(bus.data_out);
         otq.push_back($time);
      end
      if (bus.busy) busy_cnt++;
   end
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic cycle(input logic v, input logic [7:0] d);
      @(negedge clk);
      bus.data_in_valid = v;
      bus.data_in = d;
   endtask
   task automatic run_frame(input int gap, input int extra);
      outq.delete();
      otq.delete();
      itq.delete();
      busy_cnt = 0;
      for (int i = 0; i < N; i++) begin
         cycle(1'b1, img[i]);
         itq.push_back($time);
         repeat (gap) cycle(1'b0, 8'd0);
      end
      repeat (extra) cycle(1'b1, 8'd255);
      for (int t = 0; t < 100 && outq.size() < N; t++) cycle(1'b0, 8'd0);
      repeat (3) cycle(1'b0, 8'd0);
      chk("out_count", outq.size(), N);
   endtask
   // kind 0: all zero; 1: strong at (2,3) lights its 3x3 block; 2: only (1,1) lit
   task automatic check_frame(input string tag, input int kind);
      for (int k = 0; k < N; k++) begin
         int r = k / W;
         int c = k % W;
         int e = kind == 1 ? ((r >= 1 && r <= 3 && c >= 2 && c <= 4) ? 255 : 0) :
                 kind == 2 ? ((r == 1 && c == 1) ? 255 : 0) : 0;
         chk($sformatf("%s[%0d]", tag, k), k < outq.size() ? int'(outq[k]) : -1, e);
      end
   endtask
   task automatic check_latency(input string tag);
      for (int k = 0; k + W + 1 < N; k++)
         chk($sformatf("%s[%0d]", tag, k),
             (k < otq.size() && k + W + 1 < itq.size()) ? int'(otq[k] - itq[k + W + 1]) : -1, 10);
   endtask
   initial begin
      bus.data_in_valid = 1'b0;
      bus.data_in = 8'd0;
      @(negedge clk);
      chk("rst_valid", int'(bus.data_out_valid), 0);
      chk("rst_data", int'(bus.data_out), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      rst = 1'b0;
      repeat (2) cycle(1'b0, 8'd0);
      for (int i = 0; i < N; i++) img[i] = 8'd128;
      run_frame(0, 0);
      check_frame("all_mid", 0);
      chk("busy_cycles", busy_cnt, W + 1);
      img[2 * W + 3] = 8'd255;
      run_frame(0, 0);
      check_frame("single", 1);
      check_latency("lat_cont");
      refq = outq;
      run_frame(2, 0);
      check_frame("sparse", 1);
      check_latency("lat_sparse");
      for (int k = 0; k < N; k++)
         chk($sformatf("sparse_vs_cont[%0d]", k), k < outq.size() ? int'(outq[k]) : -1, int'(refq[k]));
      run_frame(0, 2);
      chk("overrun_set", int'(bus.overrun), 1);
      chk("ovr_busy_cycles", busy_cnt, W + 1);
      check_frame("ovr_frame", 1);
      img[2 * W + 3] = 8'd128;
      run_frame(0, 0);
      check_frame("after_ovr", 0);
      chk("overrun_sticky", int'(bus.overrun), 1);
      for (int i = 0; i < N; i++) img[i] = 8'd0;
      img[0] = 8'd255;
      img[W + 1] = 8'd128;
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'd128);
      #2;
      chk("pre_rst_valid", int'(bus.data_out_valid), 1);
      rst = 1'b1;
      bus.data_in_valid = 1'b0;
      #1;
      chk("mid_rst_valid", int'(bus.data_out_valid), 0);
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_overrun", int'(bus.overrun), 0);
      @(negedge clk);
      rst = 1'b0;
      run_frame(0, 0);
      check_frame("border", 2);
      chk("post_rst_overrun", int'(bus.overrun), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
